// File: rtl/display_pkg.sv
// Shared types and constants for the front-panel display sequencer.
package display_pkg;

  typedef enum logic [2:0] {
    VIEW_CLOCK = 3'd0,
    VIEW_DATE  = 3'd1,
    VIEW_DDAY  = 3'd2,
    EDIT_CLOCK = 3'd3,
    EDIT_DATE  = 3'd4,
    EDIT_DDAY  = 3'd5
  } state_t;

  localparam logic [2:0] MODE_CLOCK = 3'b001;
  localparam logic [2:0] MODE_DATE  = 3'b010;
  localparam logic [2:0] MODE_DDAY  = 3'b100;

  localparam int SEL_W   = 15;
  localparam int CLK_LO  = 0;
  localparam int CLK_HI  = 2;
  localparam int DATE_LO = 3;
  localparam int DATE_HI = 8;
  localparam int DDAY_LO = 9;
  localparam int DDAY_HI = 14;

  function automatic logic is_edit(state_t s);
    return (s == EDIT_CLOCK) || (s == EDIT_DATE) || (s == EDIT_DDAY);
  endfunction

  function automatic logic [2:0] mode_of(state_t s);
    case (s)
      VIEW_CLOCK, EDIT_CLOCK: return MODE_CLOCK;
      VIEW_DATE,  EDIT_DATE:  return MODE_DATE;
      default:                return MODE_DDAY;
    endcase
  endfunction

  function automatic int lo_of(state_t s);
    case (s)
      VIEW_CLOCK, EDIT_CLOCK: return CLK_LO;
      VIEW_DATE,  EDIT_DATE:  return DATE_LO;
      default:                return DDAY_LO;
    endcase
  endfunction

  function automatic int hi_of(state_t s);
    case (s)
      VIEW_CLOCK, EDIT_CLOCK: return CLK_HI;
      VIEW_DATE,  EDIT_DATE:  return DATE_HI;
      default:                return DDAY_HI;
    endcase
  endfunction

  // Edit state for a view (and the view for an edit): same group, other half.
  function automatic state_t edit_of(state_t s);
    case (s)
      VIEW_CLOCK: return EDIT_CLOCK;
      VIEW_DATE:  return EDIT_DATE;
      default:    return EDIT_DDAY;
    endcase
  endfunction

  function automatic state_t view_of(state_t s);
    case (s)
      EDIT_CLOCK: return VIEW_CLOCK;
      EDIT_DATE:  return VIEW_DATE;
      default:    return VIEW_DDAY;
    endcase
  endfunction

  // Step a one-hot cursor within [lo..hi], wrapping from hi back to lo.
  function automatic logic [SEL_W-1:0] rotate_field(logic [SEL_W-1:0] sel, int lo, int hi);
    if (sel[hi]) return SEL_W'(1) << lo;
    return sel << 1;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one debounced key level.
module key_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic key_q;

  // History bit; cleared on reset so a key held through reset release fires once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) key_q <= 1'b0;
    else       key_q <= level;
  end

  assign pulse = level & ~key_q;

endmodule

// File: rtl/display_edit_ctrl.sv
// Front-panel sequencer: view cycling, field edit, cursor stepping, edit timeout.
module display_edit_ctrl
  import display_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int TO_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_1Hz,
  input  logic             key_mode,
  input  logic             key_edit,
  input  logic             key_next,
  output logic [2:0]       mode,
  output logic             set_dday,
  output logic [SEL_W-1:0] select,
  output logic             edit_active,
  output logic             commit,
  output logic             abort
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  // Key index order within the edge vector.
  localparam int K_MODE = 0;
  localparam int K_EDIT = 1;
  localparam int K_NEXT = 2;

  logic [2:0] keys, edges;
  assign keys = {key_next, key_edit, key_mode};

  key_edge_detect u_key [2:0] (
    .clock (clock),
    .reset (reset),
    .level (keys),
    .pulse (edges)
  );

  state_t           state, nxt_state;
  logic [TO_W-1:0]  cnt, nxt_cnt;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_commit, nxt_abort;
  logic [2:0]       nxt_mode;
  logic             nxt_set_dday, nxt_edit_active;

  // State, inactivity counter and all outputs registered together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= VIEW_CLOCK;
      cnt         <= '0;
      mode        <= MODE_CLOCK;
      set_dday    <= 1'b0;
      select      <= '0;
      edit_active <= 1'b0;
      commit      <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      mode        <= nxt_mode;
      set_dday    <= nxt_set_dday;
      select      <= nxt_sel;
      edit_active <= nxt_edit_active;
      commit      <= nxt_commit;
      abort       <= nxt_abort;
    end
  end

  // Next state, cursor and counter; key_edit > key_next > key_mode > timeout.
  always_comb begin
    nxt_state  = state;
    nxt_sel    = select;
    nxt_cnt    = cnt;
    nxt_commit = 1'b0;
    nxt_abort  = 1'b0;
    if (!is_edit(state)) begin
      nxt_cnt = '0;
      nxt_sel = '0;
      if (edges[K_EDIT]) begin
        nxt_state = edit_of(state);
        nxt_sel   = SEL_W'(1) << lo_of(state);
      end else if (edges[K_MODE]) begin
        case (state)
          VIEW_CLOCK: nxt_state = VIEW_DATE;
          VIEW_DATE:  nxt_state = VIEW_DDAY;
          default:    nxt_state = VIEW_CLOCK;
        endcase
      end
    end else begin
      if (edges[K_EDIT]) begin
        nxt_state  = view_of(state);
        nxt_sel    = '0;
        nxt_cnt    = '0;
        nxt_commit = 1'b1;
      end else if (edges[K_NEXT]) begin
        nxt_sel = rotate_field(select, lo_of(state), hi_of(state));
        nxt_cnt = '0;
      end else if (edges[K_MODE]) begin
        // View change is locked out while editing; the press still counts as activity.
        nxt_cnt = '0;
      end else if (tick_1Hz) begin
        if (cnt == TO_LAST) begin
          nxt_state = view_of(state);
          nxt_sel   = '0;
          nxt_cnt   = '0;
          nxt_abort = 1'b1;
        end else begin
          nxt_cnt = cnt + TO_W'(1);
        end
      end
    end
  end

  // Per-state output decode, taken from the next state so outputs stay registered.
  always_comb begin
    nxt_mode        = mode_of(nxt_state);
    nxt_set_dday    = (nxt_state == EDIT_DDAY);
    nxt_edit_active = is_edit(nxt_state);
  end

endmodule

// File: tb/tb_display_edit_ctrl.sv
// Self-checking bench: directed plan steps plus random key traffic vs a field-level model.
module tb_display_edit_ctrl;

  localparam int TIMEOUT_S = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1Hz = 1'b0;
  logic        key_mode = 1'b0;
  logic        key_edit = 1'b0;
  logic        key_next = 1'b0;
  logic [2:0]  mode;
  logic        set_dday;
  logic [14:0] select;
  logic        edit_active;
  logic        commit;
  logic        abort;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  display_edit_ctrl #(.TIMEOUT_S(TIMEOUT_S), .TO_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick_1Hz    (tick_1Hz),
    .key_mode    (key_mode),
    .key_edit    (key_edit),
    .key_next    (key_next),
    .mode        (mode),
    .set_dday    (set_dday),
    .select      (select),
    .edit_active (edit_active),
    .commit      (commit),
    .abort       (abort)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: group g (0 clock,1 date,2 dday), editing flag, field index, idle seconds.
  int g = 0, f = 0, cnt = 0;
  bit ed = 0, ecom = 0, eab = 0;
  bit pm = 0, pe = 0, pn = 0;
  int base [3] = '{0, 3, 9};
  int nf   [3] = '{3, 6, 6};

  initial begin : model
    bit em, ee, en;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        g = 0; f = 0; cnt = 0; ed = 0; ecom = 0; eab = 0;
        pm = 0; pe = 0; pn = 0;
      end else begin
        em = key_mode && !pm;
        ee = key_edit && !pe;
        en = key_next && !pn;
        pm = key_mode; pe = key_edit; pn = key_next;
        ecom = 0; eab = 0;
        if (!ed) begin
          if (ee) begin ed = 1; f = 0; cnt = 0; end
          else if (em) g = (g + 1) % 3;
        end else begin
          if (ee) begin ed = 0; ecom = 1; cnt = 0; end
          else if (en) begin f = (f + 1) % nf[g]; cnt = 0; end
          else if (em) cnt = 0;
          else if (tick_1Hz) begin
            if (cnt == TIMEOUT_S - 1) begin ed = 0; eab = 1; cnt = 0; end
            else cnt++;
          end
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("mode",        32'(mode),        32'(1 << g));
      chk("set_dday",    32'(set_dday),    32'(ed && g == 2));
      chk("select",      32'(select),      ed ? 32'(1 << (base[g] + f)) : 32'd0);
      chk("edit_active", 32'(edit_active), 32'(ed));
      chk("commit",      32'(commit),      32'(ecom));
      chk("abort",       32'(abort),       32'(eab));
      chk("onehot_sel",  32'($countones(select) <= 1), 32'd1);
      chk("commit_abort_excl", 32'(commit && abort), 32'd0);
    end
  end

  // Apply a key/tick pattern for one clock and settle just after the edge.
  task automatic drive(input logic m, input logic e, input logic n, input logic t);
    @(negedge clock);
    #1;
    key_mode = m; key_edit = e; key_next = n; tick_1Hz = t;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [14:0] date_seq [6];
    date_seq = '{15'h0010, 15'h0020, 15'h0040, 15'h0080, 15'h0100, 15'h0008};

    #12;
    chk("rst_mode",   32'(mode),   32'h1);
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_flags",  32'({set_dday, edit_active, commit, abort}), 32'h0);
    @(negedge clock); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // View cycling.
    drive(1,0,0,0); chk("view_date", 32'(mode), 32'h2);
    drive(0,0,0,0);
    drive(1,0,0,0); chk("view_dday", 32'(mode), 32'h4);
    drive(0,0,0,0);
    drive(1,0,0,0); chk("view_clock", 32'(mode), 32'h1); chk("view_sel", 32'(select), 32'h0);
    drive(0,0,0,0);

    // Date edit, cursor walk with wrap, commit.
    drive(1,0,0,0); drive(0,0,0,0);
    drive(0,1,0,0); chk("date_entry_sel", 32'(select), 32'h0008);
    chk("date_entry_act", 32'(edit_active), 32'h1);
    drive(0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      drive(0,0,1,0); chk("date_next", 32'(select), 32'(date_seq[i]));
      drive(0,0,0,0);
    end
    drive(0,1,0,0);
    chk("date_commit", 32'(commit), 32'h1);
    chk("date_commit_sel", 32'(select), 32'h0);
    chk("date_commit_mode", 32'(mode), 32'h2);
    drive(0,0,0,0); chk("commit_one_cycle", 32'(commit), 32'h0);

    // D-day edit abandoned by timeout.
    drive(1,0,0,0); drive(0,0,0,0);
    drive(0,1,0,0);
    chk("dday_set", 32'(set_dday), 32'h1);
    chk("dday_sel", 32'(select), 32'h0200);
    drive(0,0,0,0);
    for (int i = 0; i < 9; i++) drive(0,0,0,1);
    chk("dday_pre_abort", 32'(abort), 32'h0);
    drive(0,0,0,1);
    chk("dday_abort", 32'(abort), 32'h1);
    chk("dday_abort_set", 32'(set_dday), 32'h0);
    chk("dday_abort_mode", 32'(mode), 32'h4);
    drive(0,0,0,0); chk("abort_one_cycle", 32'(abort), 32'h0);

    // Clock edit: key_next on the 10th tick restarts the count.
    drive(1,0,0,0); drive(0,0,0,0);
    drive(0,1,0,0); drive(0,0,0,0);
    for (int i = 0; i < 9; i++) drive(0,0,0,1);
    drive(0,0,1,1);
    chk("clk_tick_next_abort", 32'(abort), 32'h0);
    chk("clk_tick_next_sel", 32'(select), 32'h0002);
    for (int i = 0; i < 9; i++) drive(0,0,0,1);
    chk("clk_restart_active", 32'(edit_active), 32'h1);
    drive(0,0,0,1);
    chk("clk_restart_abort", 32'(abort), 32'h1);
    drive(0,0,0,0);

    // key_edit held: one entry only; then edit+next together commits.
    drive(0,1,0,0); chk("hold_entry", 32'(select), 32'h0001);
    for (int i = 0; i < 49; i++) drive(0,1,0,0);
    chk("hold_still_edit", 32'(edit_active), 32'h1);
    chk("hold_no_commit", 32'(commit), 32'h0);
    drive(0,0,0,0);
    drive(0,1,1,0);
    chk("edit_next_commit", 32'(commit), 32'h1);
    chk("edit_next_sel", 32'(select), 32'h0);
    drive(0,0,0,0);

    // Asynchronous reset mid date-edit.
    drive(1,0,0,0); drive(0,0,0,0);
    drive(0,1,0,0); drive(0,0,1,0); drive(0,0,0,0);
    chk("pre_reset_sel", 32'(select), 32'h0010);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mode", 32'(mode), 32'h1);
    chk("async_rst_out",  32'({select, set_dday, edit_active, commit, abort}), 32'h0);
    repeat (3) @(negedge clock);
    #1; reset = 1'b0;

    // Random traffic: busy phase, then sparse keys so timeouts happen.
    for (int i = 0; i < 4000; i++) begin
      int kp, tp;
      kp = (i < 2000) ? 4 : 40;
      tp = (i < 2000) ? 4 : 2;
      @(negedge clock); #1;
      if (i % 900 == 450) reset = 1'b1;
      else if (i % 900 == 453) reset = 1'b0;
      if ($urandom_range(0, kp - 1) == 0) key_mode = ~key_mode;
      if ($urandom_range(0, kp - 1) == 0) key_edit = ~key_edit;
      if ($urandom_range(0, kp - 1) == 0) key_next = ~key_next;
      tick_1Hz = ($urandom_range(0, tp - 1) == 0);
    end
    @(negedge clock); #1;
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
